// File: rtl/fm_radio_pkg.sv
// Shared FM receiver definitions: sample widths, Q10 quantisation,
// de-emphasis coefficients, the dequantise helper and the stage FSM states.
package fm_radio_pkg;

  localparam int DATA_SIZE   = 32;
  localparam int QUANT_BITS  = 10;
  localparam int DEEMPH_TAPS = 2;

  // Q10 coefficients: B0 = B1 = 178, A0 unused (zero), A1 = -666.
  localparam logic signed [DATA_SIZE-1:0] IIR_B_COEFFS [DEEMPH_TAPS] =
    '{32'sh000000B2, 32'sh000000B2};
  localparam logic signed [DATA_SIZE-1:0] IIR_A_COEFFS [DEEMPH_TAPS] =
    '{32'sh00000000, 32'shFFFFFD66};

  typedef enum logic [1:0] {
    READ    = 2'd0,
    COMPUTE = 2'd1,
    WRITE   = 2'd2
  } state_t;

  // Keep the low DATA_SIZE bits of the signed product, then scale down by
  // 2^QUANT_BITS truncating toward zero. Negative values are handled through
  // their unsigned magnitude so even the most negative product rounds the
  // right way.
  function automatic logic signed [DATA_SIZE-1:0] DEQUANTIZE(
    input logic signed [DATA_SIZE-1:0] coeff,
    input logic signed [DATA_SIZE-1:0] sample
  );
    logic signed [2*DATA_SIZE-1:0] full;
    logic [DATA_SIZE-1:0] low;
    logic [DATA_SIZE-1:0] mag;
    full = coeff * sample;
    low  = full[DATA_SIZE-1:0];
    if (low[DATA_SIZE-1]) begin
      mag = (~low + 1'b1) >> QUANT_BITS;
      return $signed(~mag + 1'b1);
    end else begin
      return $signed(low >> QUANT_BITS);
    end
  endfunction

endpackage

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis stage between the audio low-pass FIR and the
// gain stage. Pops a sample, runs one MAC per cycle over TAPS taps, then
// pushes the result downstream.
// Optional build macro: DEEMPH_SAT_EN clamps the written value to 16-bit range.
//
// Handshake: x_rd_en is a combinational pop, asserted only in READ while
// x_empty=0 (data on x_in is consumed on that clock edge). y_wr_en is a
// registered one-cycle push, issued only when y_out_full=0 in WRITE; y_out is
// valid in the same cycle y_wr_en is high.
module iir_deemph #(
  parameter int TAPS       = fm_radio_pkg::DEEMPH_TAPS,
  parameter int DECIMATION = 1,
  parameter int DATA_SIZE  = fm_radio_pkg::DATA_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  output logic                 x_rd_en,
  input  logic                 x_empty,
  output logic [DATA_SIZE-1:0] y_out,
  input  logic                 y_out_full,
  output logic                 y_wr_en
);
  import fm_radio_pkg::*;

  localparam int CNT_MAX = (TAPS > DECIMATION) ? TAPS : DECIMATION;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (TAPS > 1) ? $clog2(TAPS) : 1;

`ifdef DEEMPH_SAT_EN
  localparam logic signed [DATA_SIZE-1:0] SAT_MAX = 32767;
  localparam logic signed [DATA_SIZE-1:0] SAT_MIN = -32768;
`endif

  state_t                      state;
  state_t                      next_state;
  logic [CNT_W-1:0]            count;
  logic signed [DATA_SIZE-1:0] sum;
  logic signed [DATA_SIZE-1:0] x_hist [TAPS];
  logic signed [DATA_SIZE-1:0] y_hist [TAPS];

  logic                        last_read;
  logic                        last_tap;
  logic [IDX_W-1:0]            tap_idx;
  logic [IDX_W-1:0]            fb_idx;
  logic signed [DATA_SIZE-1:0] b_term;
  logic signed [DATA_SIZE-1:0] a_term;
  logic signed [DATA_SIZE-1:0] write_val;

  // Counter end conditions for the decimating read and the tap sweep.
  always_comb begin
    last_read = (count == CNT_W'(DECIMATION - 1));
    last_tap  = (count == CNT_W'(TAPS - 1));
  end

  // Next-state and pop strobe; unknown encodings fall back to READ.
  always_comb begin
    next_state = state;
    x_rd_en    = 1'b0;
    case (state)
      READ: begin
        if (!x_empty) begin
          x_rd_en = 1'b1;
          if (last_read) next_state = COMPUTE;
        end
      end
      COMPUTE: begin
        if (last_tap) next_state = WRITE;
      end
      WRITE: begin
        if (!y_out_full) next_state = READ;
      end
      default: next_state = READ;
    endcase
  end

  // Per-tap products: feed-forward on x_hist[i], feedback on y_hist[i-1]
  // (no feedback term on tap 0).
  always_comb begin
    tap_idx = IDX_W'(count);
    fb_idx  = tap_idx - 1'b1;
    b_term  = DEQUANTIZE(IIR_B_COEFFS[tap_idx], x_hist[tap_idx]);
    if (tap_idx == '0) a_term = '0;
    else               a_term = DEQUANTIZE(IIR_A_COEFFS[tap_idx], y_hist[fb_idx]);
  end

  // Value written out and fed back into the output history.
  always_comb begin
`ifdef DEEMPH_SAT_EN
    if (sum > SAT_MAX)      write_val = SAT_MAX;
    else if (sum < SAT_MIN) write_val = SAT_MIN;
    else                    write_val = sum;
`else
    write_val = sum;
`endif
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= READ;
    else       state <= next_state;
  end

  // Datapath: history shifts, MAC accumulation and the output push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      sum     <= '0;
      y_out   <= '0;
      y_wr_en <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_hist[i] <= '0;
        y_hist[i] <= '0;
      end
    end else begin
      y_wr_en <= 1'b0;
      case (state)
        READ: begin
          if (!x_empty) begin
            x_hist[0] <= x_in;
            for (int i = 1; i < TAPS; i++) x_hist[i] <= x_hist[i-1];
            count <= last_read ? '0 : count + 1'b1;
          end
        end
        COMPUTE: begin
          sum   <= sum + b_term + a_term;
          count <= last_tap ? '0 : count + 1'b1;
        end
        WRITE: begin
          if (!y_out_full) begin
            y_out     <= write_val;
            y_wr_en   <= 1'b1;
            y_hist[0] <= write_val;
            for (int i = 1; i < TAPS; i++) y_hist[i] <= y_hist[i-1];
            sum       <= '0;
          end
        end
        default: begin
          count <= '0;
          sum   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Self-checking bench for iir_deemph: directed steps in one initial block,
// a reference model feeding an expected-value queue, and a negedge monitor
// that pops and compares every push the DUT makes.
module tb_iir_deemph;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] x_in;
  logic        x_rd_en;
  logic        x_empty;
  logic [31:0] y_out;
  logic        y_out_full;
  logic        y_wr_en;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          lat_en = 1'b1;
  logic [31:0] exp_q[$];
  int          pop_q[$];
  logic [31:0] last_exp = '0;
  logic signed [31:0] m_x1;
  logic signed [31:0] m_y1;

  iir_deemph dut (
    .clock      (clock),
    .reset      (reset),
    .x_in       (x_in),
    .x_rd_en    (x_rd_en),
    .x_empty    (x_empty),
    .y_out      (y_out),
    .y_out_full (y_out_full),
    .y_wr_en    (y_wr_en)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(obs), obs, $signed(exp_v), exp_v);
    end
  endtask

  // Reference dequantise: integer division truncates toward zero.
  function automatic logic signed [31:0] m_dq(input longint c, input longint d);
    longint full;
    logic signed [31:0] low;
    longint l;
    longint q;
    logic [63:0] qb;
    full = c * d;
    low  = full[31:0];
    l    = low;
    if (l < 0) q = -((-l) / 1024);
    else       q = l / 1024;
    qb = q;
    return qb[31:0];
  endfunction

  // Reference filter step; pushes the expected output when a sample is popped.
  task automatic model_step(input logic signed [31:0] v);
    longint s;
    logic [63:0] sb;
    logic signed [31:0] y;
    s  = longint'(m_dq(178, v)) + longint'(m_dq(178, m_x1)) + longint'(m_dq(-666, m_y1));
    sb = s;
    y  = sb[31:0];
`ifdef DEEMPH_SAT_EN
    if (y > 32767)       y = 32767;
    else if (y < -32768) y = -32768;
`endif
    exp_q.push_back(y);
    m_x1 = v;
    m_y1 = y;
  endtask

  // Output monitor / scoreboard.
  always @(negedge clock) begin
    logic [31:0] e;
    int pc;
    cyc++;
    if (x_rd_en === 1'b1) pop_q.push_back(cyc);
    if (y_wr_en === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_push observed=%0d expected=no_push", $signed(y_out));
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("y_out", y_out, e);
        last_exp = e;
        if (pop_q.size() != 0) begin
          pc = pop_q.pop_front();
          if (lat_en) check("latency", 32'(cyc - pc), 32'd4);
        end
      end
    end
  end

  task automatic do_reset();
    reset      = 1'b1;
    x_empty    = 1'b1;
    y_out_full = 1'b0;
    x_in       = '0;
    exp_q.delete();
    pop_q.delete();
    m_x1 = 0;
    m_y1 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_y_out", y_out, 32'd0);
    check("rst_y_wr_en", {31'd0, y_wr_en}, 32'd0);
    check("rst_x_rd_en", {31'd0, x_rd_en}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) for the DUT to pop the value currently on x_in.
  task automatic wait_pop(input logic signed [31:0] v);
    int budget;
    budget = 0;
    @(negedge clock);
    while (x_rd_en !== 1'b1 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    check("pop_seen", {31'd0, x_rd_en}, 32'd1);
    if (x_rd_en === 1'b1) model_step(v);
    @(posedge clock);
    #1 x_empty = 1'b1;
  endtask

  task automatic drive_sample(input logic signed [31:0] v);
    @(posedge clock);
    #1;
    x_in    = v;
    x_empty = 1'b0;
    wait_pop(v);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clock);
      b++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    logic signed [31:0] v;
    int b;

    // Reset state.
    do_reset();

    // Step response to a constant 1024.
    for (int i = 0; i < 8; i++) drive_sample(32'sd1024);
    drain();

    // Negative impulse then zeros: symmetric truncation on negative products.
    do_reset();
    drive_sample(-32'sd1024);
    for (int i = 0; i < 4; i++) drive_sample(32'sd0);
    drain();

    // Small input: every product term truncates to zero.
    do_reset();
    for (int i = 0; i < 5; i++) drive_sample(32'sd5);
    drain();

    // Mixed random samples, including full-range values that wrap.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2) v = $signed($urandom());
      else            v = $signed($urandom_range(0, 8191)) - 32'sd4096;
      drive_sample(v);
    end
    drive_sample(32'sh7FFFFFFF);
    drive_sample(32'sh80000000);
    drain();

    // Downstream back-pressure while in WRITE.
    lat_en     = 1'b0;
    y_out_full = 1'b1;
    drive_sample(32'sd3000);
    repeat (2) @(posedge clock);
    #1;
    x_in    = 32'sd777;
    x_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_wr_en", {31'd0, y_wr_en}, 32'd0);
      check("stall_rd_en", {31'd0, x_rd_en}, 32'd0);
      check("stall_y_out", y_out, last_exp);
    end
    @(posedge clock);
    #1 y_out_full = 1'b0;
    wait_pop(32'sd777);
    drain();
    lat_en = 1'b1;

    // Reset in the second COMPUTE cycle drops the pending result and history.
    drive_sample(32'sd2000);
    @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    pop_q.delete();
    m_x1 = 0;
    m_y1 = 0;
    @(negedge clock);
    check("midrst_y_wr_en", {31'd0, y_wr_en}, 32'd0);
    check("midrst_y_out", y_out, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive_sample(32'sd1024);
    b = 0;
    while (y_wr_en !== 1'b1 && b < 20) begin
      @(negedge clock);
      b++;
    end
    check("post_rst_178", y_out, 32'd178);
    drain();

    // Large positive input: wrapped (or clamped) value against the model.
    drive_sample(32'sh7FFFFFFF);
    drive_sample(32'sh7FFFFFFF);
    drive_sample(32'sh00FFFFFF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
